// File: rtl/sn_to_bn.sv
// sn_to_bn: counts ones per lane over a frame of LANES stochastic bit-streams and emits 4-bit binary values.
// Define SN2BN_FRAME_CNT_EN to add an 8-bit wrapping count of completed frames on o_frame_cnt.
module sn_to_bn #(
  parameter int LANES   = 4,
  parameter int WIN_LEN = 16
) (
  input  logic                  i_clk_sn2bn,
  input  logic                  i_rst_n_sn2bn,
  input  logic                  i_start_sn2bn,
  input  logic                  i_stop_sn2bn,
  input  logic                  i_sn_valid,
  input  logic [LANES-1:0]      i_sn_bit,
  output logic [LANES-1:0][3:0] o_x_bn,
  output logic                  o_valid,
  output logic                  o_busy
`ifdef SN2BN_FRAME_CNT_EN
  ,
  output logic [7:0]            o_frame_cnt
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Index of the final bit of a full frame, compared against the pre-increment bit count.
  localparam logic [4:0] LAST_IDX = 5'(WIN_LEN - 1);

  logic [1:0]            state_q;
  logic [1:0]            state_d;
  logic [4:0]            bit_cnt_q;
  logic [4:0]            bit_cnt_d;
  logic [LANES-1:0][4:0] lane_cnt_q;
  logic [LANES-1:0][4:0] lane_cnt_d;
  logic [LANES-1:0][3:0] x_bn_d;
  logic                  go;
  logic                  load_x;

  // A simultaneous stop always overrides start.
  assign go = i_start_sn2bn & ~i_stop_sn2bn;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    lane_cnt_d = lane_cnt_q;
    load_x     = 1'b0;

    case (state_q)
      IDLE: begin
        if (go) begin
          state_d    = ACC;
          bit_cnt_d  = '0;
          lane_cnt_d = '0;
        end
      end

      ACC: begin
        if (i_stop_sn2bn) begin
          state_d = IDLE;
        end else if (i_start_sn2bn) begin
          bit_cnt_d  = '0;
          lane_cnt_d = '0;
        end else if (i_sn_valid) begin
          bit_cnt_d = bit_cnt_q + 5'd1;
          for (int k = 0; k < LANES; k++) begin
            lane_cnt_d[k] = lane_cnt_q[k] + 5'(i_sn_bit[k]);
          end
          if (bit_cnt_q == LAST_IDX) begin
            state_d = DONE;
            load_x  = 1'b1;
          end
        end else if (bit_cnt_q != '0) begin
          // Stream paused after at least one bit: close the frame early.
          state_d = DONE;
          load_x  = 1'b1;
        end
      end

      DONE: begin
        if (go) begin
          state_d    = ACC;
          bit_cnt_d  = '0;
          lane_cnt_d = '0;
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // A full 16-bit frame of ones counts to 16, which saturates to the 4-bit maximum.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      x_bn_d[k] = (lane_cnt_d[k] > 5'd15) ? 4'hF : lane_cnt_d[k][3:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk_sn2bn or negedge i_rst_n_sn2bn) begin
    if (!i_rst_n_sn2bn) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      // NOTE: the lane counters are a handful of flops rather than a RAM, so they take the async reset like all other state.
      lane_cnt_q <= '0;
      o_x_bn     <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      lane_cnt_q <= lane_cnt_d;
      if (load_x) begin
        o_x_bn <= x_bn_d;
      end
    end
  end

  assign o_valid = (state_q == DONE);
  assign o_busy  = (state_q == ACC);

`ifdef SN2BN_FRAME_CNT_EN
  always_ff @(posedge i_clk_sn2bn or negedge i_rst_n_sn2bn) begin
    if (!i_rst_n_sn2bn) begin
      o_frame_cnt <= '0;
    end else if (o_valid) begin
      o_frame_cnt <= o_frame_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sn_to_bn.sv
// Self-checking bench for sn_to_bn: directed frames plus randomized frames against a ones-counting model.
module tb_sn_to_bn;

  localparam int LANES   = 4;
  localparam int WIN_LEN = 16;

  typedef logic [LANES-1:0]      vec_t;
  typedef logic [LANES-1:0][3:0] xbn_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       sn_valid;
  vec_t       sn_bit;
  xbn_t       x_bn;
  logic       valid;
  logic       busy;
`ifdef SN2BN_FRAME_CNT_EN
  logic [7:0] frame_cnt;
`endif

  int   tests_run    = 0;
  int   tests_failed = 0;
  xbn_t last_x       = '0;

  always #5 clk = ~clk;

  sn_to_bn #(.LANES(LANES), .WIN_LEN(WIN_LEN)) dut (
    .i_clk_sn2bn   (clk),
    .i_rst_n_sn2bn (rst_n),
    .i_start_sn2bn (start),
    .i_stop_sn2bn  (stop),
    .i_sn_valid    (sn_valid),
    .i_sn_bit      (sn_bit),
    .o_x_bn        (x_bn),
    .o_valid       (valid),
    .o_busy        (busy)
`ifdef SN2BN_FRAME_CNT_EN
    ,
    .o_frame_cnt   (frame_cnt)
`endif
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: per lane, number of ones in the frame, capped at 15.
  function automatic xbn_t model(input vec_t bits[$]);
    xbn_t r;
    int   c;
    for (int k = 0; k < LANES; k++) begin
      c = 0;
      foreach (bits[i]) c += int'(bits[i][k]);
      r[k] = (c > 15) ? 4'd15 : 4'(c);
    end
    return r;
  endfunction

  // Start a frame, wait `lead` idle cycles, stream `bits`, then drop valid and observe.
  // lat: 0 = o_valid seen right after the edge taking the last bit, j = j edges later.
  task automatic run_frame(input vec_t bits[$], input int lead,
                           output int lat, output int pulses, output xbn_t got);
    lat = -1; pulses = 0; got = '0;
    start = 1'b1; stop = 1'b0; sn_valid = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < lead; i++) begin
      sn_bit = vec_t'($urandom);
      tick();
      if (valid) pulses++;
    end
    foreach (bits[i]) begin
      sn_valid = 1'b1;
      sn_bit   = bits[i];
      tick();
      if (valid) begin
        pulses++;
        got = x_bn;
        if (i == bits.size() - 1) lat = 0;
      end
    end
    sn_valid = 1'b0;
    sn_bit   = vec_t'($urandom);
    for (int j = 1; j <= 4; j++) begin
      tick();
      if (valid) begin
        pulses++;
        got = x_bn;
        if (lat < 0) lat = j;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; sn_valid = 1'b0; sn_bit = '0;
    #12;
    tests_run++; if (valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got=%b exp=0", valid); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests_run++; if (x_bn !== '0) begin tests_failed++; $display("FAIL reset_x_bn got=%h exp=0000", x_bn); end
    @(negedge clk);
    rst_n = 1'b1;
    // Without a start pulse the stream must be ignored.
    for (int i = 0; i < 6; i++) begin
      sn_valid = 1'($urandom);
      sn_bit   = vec_t'($urandom);
      tick();
      tests_run++;
      if (busy !== 1'b0 || valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL idle_no_start busy=%b valid=%b exp busy=0 valid=0", busy, valid);
      end
    end
    sn_valid = 1'b0;
  endtask

  task automatic test_full_frame();
    vec_t q[$];
    int   lat, pulses;
    xbn_t got;
    for (int t = 0; t < WIN_LEN; t++) begin
      q.push_back({(t % 2 == 0), (t % 2 == 0), 1'b0, 1'b1});
    end
    run_frame(q, 0, lat, pulses, got);
    tests_run++; if (got !== 16'h880F) begin tests_failed++; $display("FAIL full_frame_x_bn got=%h exp=880f", got); end
    tests_run++; if (pulses !== 1) begin tests_failed++; $display("FAIL full_frame_pulses got=%0d exp=1", pulses); end
    tests_run++; if (lat !== 0) begin tests_failed++; $display("FAIL full_frame_latency got=%0d exp=0", lat); end
    last_x = 16'h880F;
  endtask

  task automatic test_loopback();
    vec_t q[$];
    int   v[LANES];
    int   lat, pulses;
    xbn_t got;
    vec_t b;
    v[0] = 8; v[1] = 4; v[2] = 2; v[3] = 15;
    // 7 is odd, so t*7 mod 16 visits every residue once: exactly v[k] ones per lane.
    for (int t = 0; t < WIN_LEN; t++) begin
      for (int k = 0; k < LANES; k++) b[k] = (((t * 7 + k * 3) % 16) < v[k]);
      q.push_back(b);
    end
    run_frame(q, 1, lat, pulses, got);
    tests_run++; if (got !== 16'hF248) begin tests_failed++; $display("FAIL loopback_x_bn got=%h exp=f248", got); end
    tests_run++; if (pulses !== 1) begin tests_failed++; $display("FAIL loopback_pulses got=%0d exp=1", pulses); end
    last_x = 16'hF248;
  endtask

  task automatic test_early_end();
    vec_t q[$];
    int   lat, pulses;
    xbn_t got;
    for (int t = 0; t < 5; t++) q.push_back('1);
    run_frame(q, 0, lat, pulses, got);
    tests_run++; if (got !== 16'h5555) begin tests_failed++; $display("FAIL early_end_x_bn got=%h exp=5555", got); end
    tests_run++; if (pulses !== 1) begin tests_failed++; $display("FAIL early_end_pulses got=%0d exp=1", pulses); end
    tests_run++; if (lat !== 1) begin tests_failed++; $display("FAIL early_end_latency got=%0d exp=1", lat); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL early_end_idle busy=%b exp=0", busy); end
    last_x = 16'h5555;
  endtask

  task automatic test_stop();
    int pulses = 0;
    start = 1'b1; tick(); start = 1'b0;
    for (int t = 0; t < 7; t++) begin
      sn_valid = 1'b1;
      sn_bit   = vec_t'($urandom);
      tick();
      if (valid) pulses++;
    end
    sn_valid = 1'b0;
    stop     = 1'b1;
    tick();
    stop = 1'b0;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL stop_busy got=%b exp=0", busy); end
    for (int t = 0; t < 4; t++) begin
      tick();
      if (valid) pulses++;
    end
    tests_run++; if (pulses !== 0) begin tests_failed++; $display("FAIL stop_pulses got=%0d exp=0", pulses); end
    tests_run++; if (x_bn !== last_x) begin tests_failed++; $display("FAIL stop_x_bn_held got=%h exp=%h", x_bn, last_x); end
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    tests_run++; if (busy !== 1'b0 || valid !== 1'b0) begin tests_failed++; $display("FAIL start_stop_idle busy=%b valid=%b exp 0 0", busy, valid); end
    tick();
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL start_stop_idle2 busy=%b exp=0", busy); end
  endtask

  task automatic test_restart();
    vec_t q[$];
    int   pulses = 0;
    xbn_t got = '0;
    xbn_t exp;
    start = 1'b1; tick(); start = 1'b0;
    for (int t = 0; t < 5; t++) begin
      sn_valid = 1'b1; sn_bit = '1; tick();
      if (valid) pulses++;
    end
    sn_valid = 1'b0;
    start    = 1'b1;
    tick();
    start = 1'b0;
    if (valid) pulses++;
    for (int t = 0; t < WIN_LEN; t++) q.push_back(vec_t'($urandom));
    foreach (q[i]) begin
      sn_valid = 1'b1; sn_bit = q[i]; tick();
      if (valid) begin pulses++; got = x_bn; end
    end
    sn_valid = 1'b0;
    for (int t = 0; t < 3; t++) begin tick(); if (valid) pulses++; end
    exp = model(q);
    tests_run++; if (pulses !== 1) begin tests_failed++; $display("FAIL restart_pulses got=%0d exp=1", pulses); end
    tests_run++; if (got !== exp) begin tests_failed++; $display("FAIL restart_x_bn got=%h exp=%h", got, exp); end
    last_x = exp;
  endtask

  task automatic test_back_to_back();
    vec_t a[$];
    vec_t b[$];
    xbn_t ea, eb;
    for (int t = 0; t < WIN_LEN; t++) begin
      a.push_back(vec_t'($urandom));
      b.push_back(vec_t'($urandom));
    end
    ea = model(a);
    eb = model(b);
    start = 1'b1; tick(); start = 1'b0;
    foreach (a[i]) begin sn_valid = 1'b1; sn_bit = a[i]; tick(); end
    sn_valid = 1'b0;
    tests_run++; if (valid !== 1'b1 || x_bn !== ea) begin tests_failed++; $display("FAIL b2b_first valid=%b x_bn=%h exp valid=1 x_bn=%h", valid, x_bn, ea); end
    start = 1'b1;
    tick();
    start = 1'b0;
    tests_run++; if (busy !== 1'b1 || valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_rearm busy=%b valid=%b exp 1 0", busy, valid); end
    foreach (b[i]) begin sn_valid = 1'b1; sn_bit = b[i]; tick(); end
    sn_valid = 1'b0;
    tests_run++; if (valid !== 1'b1 || x_bn !== eb) begin tests_failed++; $display("FAIL b2b_second valid=%b x_bn=%h exp valid=1 x_bn=%h", valid, x_bn, eb); end
    tick();
    tests_run++; if (valid !== 1'b0 || busy !== 1'b0 || x_bn !== eb) begin tests_failed++; $display("FAIL b2b_after valid=%b busy=%b x_bn=%h exp 0 0 %h", valid, busy, x_bn, eb); end
    last_x = eb;
  endtask

  task automatic test_random();
    for (int f = 0; f < 25; f++) begin
      vec_t q[$];
      int   n, lead, lat, pulses, exp_lat;
      xbn_t got, exp;
      n    = $urandom_range(1, WIN_LEN);
      lead = $urandom_range(0, 3);
      for (int t = 0; t < n; t++) q.push_back(vec_t'($urandom));
      exp     = model(q);
      exp_lat = (n == WIN_LEN) ? 0 : 1;
      run_frame(q, lead, lat, pulses, got);
      tests_run++; if (got !== exp) begin tests_failed++; $display("FAIL random_x_bn frame=%0d len=%0d got=%h exp=%h", f, n, got, exp); end
      tests_run++; if (pulses !== 1) begin tests_failed++; $display("FAIL random_pulses frame=%0d got=%0d exp=1", f, pulses); end
      tests_run++; if (lat !== exp_lat) begin tests_failed++; $display("FAIL random_latency frame=%0d len=%0d got=%0d exp=%0d", f, n, lat, exp_lat); end
      tests_run++; if (x_bn !== exp) begin tests_failed++; $display("FAIL random_hold frame=%0d got=%h exp=%h", f, x_bn, exp); end
      last_x = exp;
    end
  endtask

  task automatic test_reset_mid_frame();
    int pulses = 0;
    start = 1'b1; tick(); start = 1'b0;
    for (int t = 0; t < 10; t++) begin
      sn_valid = 1'b1; sn_bit = vec_t'($urandom); tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++; if (x_bn !== '0) begin tests_failed++; $display("FAIL midreset_x_bn got=%h exp=0000 (prev %h)", x_bn, last_x); end
    tests_run++; if (busy !== 1'b0 || valid !== 1'b0) begin tests_failed++; $display("FAIL midreset_flags busy=%b valid=%b exp 0 0", busy, valid); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    sn_valid = 1'b0;
    for (int t = 0; t < 10; t++) begin
      sn_valid = 1'($urandom);
      sn_bit   = vec_t'($urandom);
      tick();
      if (valid || busy) pulses++;
    end
    sn_valid = 1'b0;
    tests_run++; if (pulses !== 0) begin tests_failed++; $display("FAIL midreset_after got=%0d active cycles exp=0", pulses); end
    last_x = '0;
  endtask

`ifdef SN2BN_FRAME_CNT_EN
  task automatic test_frame_cnt();
    rst_n = 1'b0; #3; rst_n = 1'b1;
    tick();
    tests_run++; if (frame_cnt !== 8'd0) begin tests_failed++; $display("FAIL frame_cnt_reset got=%0d exp=0", frame_cnt); end
    for (int f = 0; f < 259; f++) begin
      start = 1'b1; tick(); start = 1'b0;
      sn_valid = 1'b1; sn_bit = vec_t'($urandom); tick();
      sn_valid = 1'b0; tick(); tick();
      if (f == 255) begin
        tests_run++; if (frame_cnt !== 8'd0) begin tests_failed++; $display("FAIL frame_cnt_wrap got=%0d exp=0", frame_cnt); end
      end
    end
    tests_run++; if (frame_cnt !== 8'd3) begin tests_failed++; $display("FAIL frame_cnt_after got=%0d exp=3", frame_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_full_frame();
    test_loopback();
    test_early_end();
    test_stop();
    test_restart();
    test_back_to_back();
    test_random();
    test_reset_mid_frame();
`ifdef SN2BN_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sn_to_bn.md
SN_TO_BN -- requirements
Module: sn_to_bn

Interface
REQ-001 Parameter LANES, default 4: number of parallel stochastic lanes.
REQ-002 Parameter WIN_LEN, default 16: bits per frame; legal range 2..16.
REQ-003 i_clk_sn2bn  input  1  Single clock; all state updates on its rising edge.
REQ-004 i_rst_n_sn2bn  input  1  Reset; asynchronous assertion, active-low.
REQ-005 i_start_sn2bn  input  1  Frame start pulse; clears accumulators.
REQ-006 i_stop_sn2bn  input  1  Abort current frame.
REQ-007 i_sn_valid  input  1  Stream bits valid this cycle; driven by the encoder's o_isgen.
REQ-008 i_sn_bit  input  [LANES-1:0] x 1  One stochastic bit per lane.
REQ-009 o_x_bn  output  [LANES-1:0] x 4  Decoded unsigned binary value per lane.
REQ-010 o_valid  output  1  One-cycle pulse: o_x_bn updated.
REQ-011 o_busy  output  1  High while a frame is being accumulated.

Function
REQ-012 FSM states SHALL be IDLE, ACC and DONE, in registered 2-bit state.
REQ-013 IDLE: i_start_sn2bn=1 -> ACC next cycle, lane counters and bit counter cleared to 0; i_sn_valid and i_sn_bit ignored.
REQ-014 ACC: each cycle with i_sn_valid=1, lane counter k += i_sn_bit[k] and bit counter += 1.
REQ-015 Lane and bit counters SHALL be 5 bits; no wrap possible for WIN_LEN<=16.
REQ-016 ACC -> DONE when the accepted bit is the WIN_LEN-th bit of the frame.
REQ-017 ACC -> DONE when i_sn_valid=0 and bit counter >= 1 (early frame end).
REQ-018 ACC with i_sn_valid=0 and bit counter = 0: remain in ACC (waiting for first bit).
REQ-019 On ACC->DONE, o_x_bn[k] SHALL load min(lane counter k including the current bit, 15).
REQ-020 DONE lasts exactly one cycle with o_valid=1; latency is one cycle from the last accepted bit to o_valid.
REQ-021 DONE -> ACC if i_start_sn2bn=1 (counters cleared), otherwise DONE -> IDLE.
REQ-022 i_stop_sn2bn=1 in ACC -> IDLE next cycle; no o_valid; o_x_bn retains previous value.
REQ-023 i_start_sn2bn=1 in ACC without stop: restart, counters cleared, no o_valid for the aborted frame.
REQ-024 i_start_sn2bn and i_stop_sn2bn both high: stop wins; next state IDLE.
REQ-025 o_busy SHALL equal (state == ACC).
REQ-026 o_x_bn SHALL hold its value between o_valid pulses.

Reset
REQ-027 i_rst_n_sn2bn=0 SHALL immediately force state IDLE, all counters 0, o_x_bn all 0, o_valid 0, o_busy 0.
REQ-028 Reset asserted mid-frame SHALL discard the frame; no o_valid after release.
REQ-029 After release, first state change requires i_start_sn2bn.

Configuration
REQ-030 Macro SN2BN_FRAME_CNT_EN defined: add output o_frame_cnt (8 bits), +1 on each o_valid, wraps 255->0, reset to 0.
REQ-031 Macro SN2BN_FRAME_CNT_EN undefined: o_frame_cnt port and its counter SHALL not exist; all other behaviour identical.

Verification
REQ-032 Start, 16 valid cycles, lane0 all 1, lane1 all 0, lanes2/3 alternate 1,0 -> o_valid one cycle after 16th bit, o_x_bn = {8,8,0,15} (lane3..lane0; 16 saturates to 15).
REQ-033 Loopback from the encoder with inputs {4'b1000,4'b0100,4'b0010,4'b1111} -> o_x_bn = {15,2,4,8} (lane3..lane0), one o_valid.
REQ-034 Start, 5 valid bits all 1, then i_sn_valid=0 -> o_valid next cycle, all lanes 5; state IDLE after.
REQ-035 Start, 7 bits, i_stop_sn2bn=1 -> no o_valid, o_x_bn unchanged, o_busy=0 next cycle; start+stop same cycle -> stays IDLE.
REQ-036 Reset asserted after 10 bits -> outputs 0 immediately, no o_valid after release; with SN2BN_FRAME_CNT_EN, 256 frames -> o_frame_cnt = 0.
